// File: rtl/ro_pkg.sv
// Shared state encoding, defaults and config record for the ring-oscillator sweep controller.
package ro_pkg;

    localparam int RO_CNT_W      = 16;
    localparam int RO_GATE_W     = 16;
    localparam int RO_SETTLE_CYC = 8;
    localparam int RO_SLOT_W     = 4;
    localparam int RO_STAGE_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_REPORT  = 3'd3,
        ST_DONE    = 3'd4
    } ro_state_t;

    // Sweep parameters captured at start; the first slot is loaded straight into the slot register.
    typedef struct packed {
        logic [RO_SLOT_W-1:0]  slot_hi;
        logic [RO_STAGE_W-1:0] stage;
    } sweep_cfg_t;

    // Slot numbers wrap through 15 back to 0.
    function automatic logic [RO_SLOT_W-1:0] next_slot(input logic [RO_SLOT_W-1:0] slot);
        return slot + 1'b1;
    endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for the asynchronous ring output; pulse lags the input by 2-3 cycles.
// No backpressure: one single-cycle pulse per synchronized rising edge.
module ro_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_sig,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= async_sig;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;

endmodule

// File: rtl/ro_sweep_ctrl.sv
// Sweeps ring-oscillator slots lo..hi: settle, count edges over a gate window, report each count; SETTLE_CYC+gate+1 cycles per slot minimum.
// Backpressure: each result is held in REPORT, oscillator stopped, until res_ready_i accepts it; abort_i drops straight to IDLE.
module ro_sweep_ctrl
    import ro_pkg::*;
#(
    parameter int CNT_W      = RO_CNT_W,
    parameter int GATE_W     = RO_GATE_W,
    parameter int SETTLE_CYC = RO_SETTLE_CYC
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              sweep_start_i,
    input  logic              abort_i,
    input  logic [3:0]        slot_lo_i,
    input  logic [3:0]        slot_hi_i,
    input  logic [4:0]        stage_sel_i,
    input  logic [GATE_W-1:0] gate_len_i,
    input  logic              ro_sig_i,
    output logic [3:0]        ro_sel_o,
    output logic [4:0]        ro_stage_o,
    output logic              ro_start_o,
    output logic              res_valid_o,
    output logic [3:0]        res_slot_o,
    output logic [CNT_W-1:0]  res_count_o,
    output logic              res_ovf_o,
    input  logic              res_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);

    ro_state_t         state;
    ro_state_t         state_nxt;
    sweep_cfg_t        cfg;
    logic [3:0]        slot;
    logic [GATE_W-1:0] gate;
    logic [TMR_W-1:0]  tmr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              sig_rise;

    logic start_ok;
    logic abort_act;
    logic settle_end;
    logic gate_end;
    logic last_slot;
    logic timed_state;

    ro_edge_sync u_edge_sync (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .async_sig (ro_sig_i),
        .rise      (sig_rise)
    );

    assign abort_act   = abort_i && (state != ST_IDLE);
    assign start_ok    = (state == ST_IDLE) && sweep_start_i && !abort_i;
    assign settle_end  = (tmr == SETTLE_LAST);
    assign gate_end    = (tmr == TMR_W'(gate - 1'b1));
    assign last_slot   = (slot == cfg.slot_hi);
    assign timed_state = (state == ST_SETTLE) || (state == ST_MEASURE);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_end) begin
                    state_nxt = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (gate_end) begin
                    state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (res_ready_i) begin
                    state_nxt = last_slot ? ST_DONE : ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Abort wins over every pending transition, including a REPORT handshake.
        if (abort_act) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        ro_start_o  = 1'b0;
        res_valid_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (state)
            ST_IDLE:    busy_o      = 1'b0;
            ST_SETTLE:  ro_start_o  = 1'b0;
            ST_MEASURE: ro_start_o  = 1'b1;
            ST_REPORT:  res_valid_o = 1'b1;
            ST_DONE:    done_o      = 1'b1;
            default:    busy_o      = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            cfg  <= '0;
            slot <= '0;
            gate <= '0;
            tmr  <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (!timed_state || (state_nxt != state)) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + 1'b1;
            end

            if (start_ok) begin
                cfg.slot_hi <= slot_hi_i;
                cfg.stage   <= stage_sel_i;
                slot        <= slot_lo_i;
                gate        <= (gate_len_i == '0) ? GATE_W'(1) : gate_len_i;
            end else if ((state == ST_REPORT) && (state_nxt == ST_SETTLE)) begin
                slot <= next_slot(slot);
            end

            // Counter holds its value through REPORT so the result needs no extra register.
            if ((state != ST_MEASURE) && (state_nxt == ST_MEASURE)) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if ((state == ST_MEASURE) && sig_rise) begin
                if (cnt == '1) begin
                    ovf <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign ro_sel_o    = slot;
    assign ro_stage_o  = cfg.stage;
    assign res_slot_o  = slot;
    assign res_count_o = cnt;
    assign res_ovf_o   = ovf;

endmodule

// File: tb/tb_ro_sweep_ctrl.sv
// Randomized bench for ro_sweep_ctrl: a default instance and a 4-bit-counter instance run in lockstep;
// a negedge monitor records phases and results, and each test compares them with expectations derived from slot range, gate and ring period.
module tb_ro_sweep_ctrl;

    localparam int SETTLE = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sweep_start;
    logic        abort;
    logic        ready;
    logic        ro_sig;
    logic [3:0]  slot_lo;
    logic [3:0]  slot_hi;
    logic [4:0]  stage;
    logic [15:0] gate_len;

    logic [3:0]  ro_sel;
    logic [4:0]  ro_stage;
    logic        ro_start;
    logic        res_valid;
    logic [3:0]  res_slot;
    logic [15:0] res_count;
    logic        res_ovf;
    logic        busy;
    logic        done;

    logic [3:0]  ro_sel4;
    logic [4:0]  ro_stage4;
    logic        ro_start4;
    logic        res_valid4;
    logic [3:0]  res_slot4;
    logic [3:0]  res_count4;
    logic        res_ovf4;
    logic        busy4;
    logic        done4;

    int ro_per = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ro_sweep_ctrl dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .sweep_start_i(sweep_start), .abort_i(abort),
        .slot_lo_i(slot_lo), .slot_hi_i(slot_hi), .stage_sel_i(stage), .gate_len_i(gate_len),
        .ro_sig_i(ro_sig), .ro_sel_o(ro_sel), .ro_stage_o(ro_stage), .ro_start_o(ro_start),
        .res_valid_o(res_valid), .res_slot_o(res_slot), .res_count_o(res_count), .res_ovf_o(res_ovf),
        .res_ready_i(ready), .busy_o(busy), .done_o(done)
    );

    ro_sweep_ctrl #(.CNT_W(4)) dut4 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .sweep_start_i(sweep_start), .abort_i(abort),
        .slot_lo_i(slot_lo), .slot_hi_i(slot_hi), .stage_sel_i(stage), .gate_len_i(gate_len),
        .ro_sig_i(ro_sig), .ro_sel_o(ro_sel4), .ro_stage_o(ro_stage4), .ro_start_o(ro_start4),
        .res_valid_o(res_valid4), .res_slot_o(res_slot4), .res_count_o(res_count4), .res_ovf_o(res_ovf4),
        .res_ready_i(ready), .busy_o(busy4), .done_o(done4)
    );

    // Free-running ring model: period ro_per cycles, transitions on the falling clock edge.
    initial begin
        ro_sig = 1'b0;
        forever begin
            if (ro_per < 2) begin
                ro_sig = 1'b0;
                @(negedge clk);
            end else begin
                ro_sig = 1'b1;
                repeat (ro_per / 2) @(negedge clk);
                ro_sig = 1'b0;
                repeat (ro_per - ro_per / 2) @(negedge clk);
            end
        end
    end

    typedef struct {
        logic [3:0]  slot;
        logic [15:0] cnt;
        logic        ovf;
        logic [3:0]  cnt4;
        logic        ovf4;
    } res_t;

    res_t       res_q[$];
    int         settle_q[$];
    int         meas_q[$];
    logic [3:0] sel_q[$];
    logic [4:0] stg_q[$];
    int         done_cnt;
    int         glitch_cnt;
    int         overlap_cnt;
    int         clr_req = 0;
    int         clr_seen = 0;
    int         run_settle = 0;
    int         run_meas = 0;
    logic [3:0] cur_sel;
    logic [4:0] cur_stg;
    logic [3:0] meas_sel;

    always @(negedge clk) begin
        res_t r;
        if (clr_seen != clr_req) begin
            res_q.delete(); settle_q.delete(); meas_q.delete(); sel_q.delete(); stg_q.delete();
            done_cnt = 0; glitch_cnt = 0; overlap_cnt = 0;
            clr_seen = clr_req;
        end
        if (rst_n !== 1'b1) begin
            run_settle = 0;
            run_meas = 0;
        end else begin
            if (busy && !ro_start && !res_valid && !done) begin
                if (run_settle == 0) begin
                    cur_sel = ro_sel;
                    cur_stg = ro_stage;
                end else if (ro_sel !== cur_sel || ro_stage !== cur_stg) begin
                    glitch_cnt++;
                end
                run_settle++;
            end else if (run_settle != 0) begin
                settle_q.push_back(run_settle);
                sel_q.push_back(cur_sel);
                stg_q.push_back(cur_stg);
                run_settle = 0;
            end
            if (ro_start) begin
                if (run_meas == 0) meas_sel = ro_sel;
                else if (ro_sel !== meas_sel) glitch_cnt++;
                run_meas++;
            end else if (run_meas != 0) begin
                meas_q.push_back(run_meas);
                run_meas = 0;
            end
            if (ro_start && (res_valid || !busy)) overlap_cnt++;
            if (res_valid !== res_valid4 || done !== done4) overlap_cnt++;
            if (res_valid && ready) begin
                r.slot = res_slot; r.cnt = res_count; r.ovf = res_ovf;
                r.cnt4 = res_count4; r.ovf4 = res_ovf4;
                res_q.push_back(r);
            end
            if (done) done_cnt++;
        end
    end

    // Reference model: slot k of a sweep, slot count, and the edge-count window for a g-cycle gate.
    function automatic int exp_slot(input int lo, input int k);
        return (lo + k) % 16;
    endfunction

    function automatic int n_slots(input int lo, input int hi);
        return ((hi - lo + 16) % 16) + 1;
    endfunction

    function automatic bit cnt_ok(input int cnt, input int g, input int p);
        return (cnt * p > g - p) && (cnt * p < g + p);
    endfunction

    task automatic clear_mon();
        clr_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic run_sweep(input int lo, input int hi, input int stg, input int g, input int per,
                             input bit rand_rdy, input bit poke, output bit timed_out);
        ro_per = per;
        repeat (30) @(posedge clk);
        clear_mon();
        @(posedge clk); #1;
        slot_lo = 4'(lo); slot_hi = 4'(hi); stage = 5'(stg); gate_len = 16'(g);
        ready = 1'b1; sweep_start = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        slot_lo = 4'($urandom); slot_hi = 4'($urandom); stage = 5'($urandom); gate_len = 16'($urandom);
        timed_out = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            sweep_start = poke && (c == 5);
            if (rand_rdy) ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        sweep_start = 1'b0;
        ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ro_per = 7;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (ro_sel !== 4'd0 || ro_stage !== 5'd0 || ro_start !== 1'b0)
            begin n_errors++; $display("FAIL reset_ro: sel=%0d stage=%0d start=%b, want 0 0 0", ro_sel, ro_stage, ro_start); end
        n_checks++;
        if (res_valid !== 1'b0 || res_slot !== 4'd0 || res_count !== 16'd0 || res_ovf !== 1'b0)
            begin n_errors++; $display("FAIL reset_res: valid=%b slot=%0d count=%0d ovf=%b, want all 0", res_valid, res_slot, res_count, res_ovf); end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin n_errors++; $display("FAIL reset_status: busy=%b done=%b, want 0 0", busy, done); end
        n_checks++;
        if (busy4 !== 1'b0 || res_count4 !== 4'd0 || ro_sel4 !== 4'd0)
            begin n_errors++; $display("FAIL reset_dut4: busy=%b count=%0d sel=%0d, want 0", busy4, res_count4, ro_sel4); end
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_hold: busy=%b without start, want 0", busy); end
    endtask

    task automatic test_basic();
        bit to;
        run_sweep(3, 5, 21, 100, 10, 1'b0, 1'b0, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL basic_timeout: no done_o pulse seen"); end
        n_checks++;
        if (res_q.size() != 3) begin n_errors++; $display("FAIL basic_nres: got %0d results, want 3", res_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (res_q[i].slot !== 4'(3 + i) || res_q[i].cnt < 9 || res_q[i].cnt > 11 || res_q[i].ovf !== 1'b0) begin
                n_errors++;
                $display("FAIL basic_res%0d: slot=%0d count=%0d ovf=%b, want slot %0d count 10+-1 ovf 0",
                         i, res_q[i].slot, res_q[i].cnt, res_q[i].ovf, 3 + i);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_errors++; $display("FAIL basic_done: %0d done pulses, want 1", done_cnt); end
        n_checks++;
        if (settle_q.size() != 3 || meas_q.size() != 3)
            begin n_errors++; $display("FAIL basic_phases: %0d settle %0d measure runs, want 3 3", settle_q.size(), meas_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (settle_q[i] != SETTLE || meas_q[i] != 100 || sel_q[i] !== 4'(3 + i) || stg_q[i] !== 5'd21) begin
                n_errors++;
                $display("FAIL basic_phase%0d: settle=%0d meas=%0d sel=%0d stage=%0d, want %0d 100 %0d 21",
                         i, settle_q[i], meas_q[i], sel_q[i], stg_q[i], SETTLE, 3 + i);
            end
        end
        n_checks++;
        if (glitch_cnt != 0 || overlap_cnt != 0)
            begin n_errors++; $display("FAIL basic_stable: glitches=%0d overlaps=%0d, want 0 0", glitch_cnt, overlap_cnt); end
    endtask

    task automatic test_wrap();
        bit to;
        int g, per;
        g = $urandom_range(20, 80);
        per = $urandom_range(5, 12);
        run_sweep(14, 1, $urandom_range(0, 31), g, per, 1'b1, 1'b0, to);
        n_checks++;
        if (to || res_q.size() != 4)
            begin n_errors++; $display("FAIL wrap_nres: timeout=%b results=%0d, want 0 4", to, res_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (res_q[i].slot !== 4'(exp_slot(14, i)) || !cnt_ok(int'(res_q[i].cnt), g, per) || sel_q[i] !== 4'(exp_slot(14, i))) begin
                n_errors++;
                $display("FAIL wrap_res%0d: slot=%0d sel=%0d count=%0d, want slot %0d count~%0d/%0d",
                         i, res_q[i].slot, sel_q[i], res_q[i].cnt, exp_slot(14, i), g, per);
            end
        end
    endtask

    task automatic test_backpressure();
        int lo, g, per;
        bit seen;
        logic [3:0] s0;
        logic [15:0] c0;
        logic o0;
        lo = $urandom_range(0, 15);
        g = $urandom_range(10, 60);
        per = $urandom_range(5, 12);
        ro_per = per;
        repeat (30) @(posedge clk);
        clear_mon();
        @(posedge clk); #1;
        slot_lo = 4'(lo); slot_hi = 4'(lo); stage = 5'd3; gate_len = 16'(g);
        ready = 1'b0; sweep_start = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL bp_valid: res_valid_o never rose, want 1"); end
        s0 = res_slot; c0 = res_count; o0 = res_ovf;
        n_checks++;
        if (s0 !== 4'(lo) || !cnt_ok(int'(c0), g, per))
            begin n_errors++; $display("FAIL bp_value: slot=%0d count=%0d, want slot %0d count~%0d/%0d", s0, c0, lo, g, per); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_slot !== s0 || res_count !== c0 || res_ovf !== o0 || ro_start !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold%0d: valid=%b slot=%0d count=%0d ovf=%b start=%b, want 1 %0d %0d %b 0",
                         c, res_valid, res_slot, res_count, res_ovf, ro_start, s0, c0, o0);
            end
        end
        @(posedge clk); #1;
        ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b1) begin n_errors++; $display("FAIL bp_accept_cycle: valid=%b, want 1", res_valid); end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || done !== 1'b1)
            begin n_errors++; $display("FAIL bp_after: valid=%b done=%b, want 0 1", res_valid, done); end
        n_checks++;
        if (res_q.size() != 1) begin n_errors++; $display("FAIL bp_nres: %0d results, want 1", res_q.size()); end
    endtask

    task automatic test_overflow();
        bit to;
        int lo;
        lo = $urandom_range(0, 15);
        run_sweep(lo, lo, 7, 200, 5, 1'b0, 1'b0, to);
        n_checks++;
        if (to || res_q.size() != 1)
            begin n_errors++; $display("FAIL ovf_nres: timeout=%b results=%0d, want 0 1", to, res_q.size()); end
        else begin
            n_checks++;
            if (res_q[0].cnt4 !== 4'd15 || res_q[0].ovf4 !== 1'b1)
                begin n_errors++; $display("FAIL ovf_sat: count=%0d ovf=%b, want 15 1", res_q[0].cnt4, res_q[0].ovf4); end
            n_checks++;
            if (res_q[0].cnt !== 16'd40 || res_q[0].ovf !== 1'b0 || res_q[0].slot !== 4'(lo))
                begin n_errors++; $display("FAIL ovf_wide: count=%0d ovf=%b slot=%0d, want 40 0 %0d", res_q[0].cnt, res_q[0].ovf, res_q[0].slot, lo); end
        end
    endtask

    task automatic test_abort();
        int lo, lo2, len2, per;
        bit found, to;
        lo = $urandom_range(0, 15);
        per = $urandom_range(5, 12);
        ro_per = per;
        repeat (30) @(posedge clk);
        clear_mon();
        @(posedge clk); #1;
        slot_lo = 4'(lo); slot_hi = 4'((lo + 4) % 16); stage = 5'd9; gate_len = 16'd40;
        ready = 1'b1; sweep_start = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (ro_start === 1'b1 && ro_sel === 4'((lo + 1) % 16)) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL abort_reach: second MEASURE never seen"); end
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || ro_start !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0)
            begin n_errors++; $display("FAIL abort_idle: busy=%b start=%b valid=%b done=%b, want 0 0 0 0", busy, ro_start, res_valid, done); end
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt != 0 || res_q.size() != 1)
            begin n_errors++; $display("FAIL abort_after: done pulses=%0d results=%0d, want 0 1", done_cnt, res_q.size()); end
        abort = 1'b1; sweep_start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; sweep_start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL start_abort_idle: busy=%b, want 0", busy); end
        lo2 = $urandom_range(0, 15);
        len2 = $urandom_range(1, 4);
        run_sweep(lo2, (lo2 + len2 - 1) % 16, 1, 30, per, 1'b0, 1'b0, to);
        n_checks++;
        if (to || res_q.size() != len2 || done_cnt != 1)
            begin n_errors++; $display("FAIL abort_restart: timeout=%b results=%0d done=%0d, want 0 %0d 1", to, res_q.size(), done_cnt, len2); end
        else for (int i = 0; i < len2; i++) begin
            n_checks++;
            if (res_q[i].slot !== 4'(exp_slot(lo2, i)) || !cnt_ok(int'(res_q[i].cnt), 30, per))
                begin n_errors++; $display("FAIL abort_restart_res%0d: slot=%0d count=%0d, want %0d ~30/%0d", i, res_q[i].slot, res_q[i].cnt, exp_slot(lo2, i), per); end
        end
    endtask

    task automatic test_gate0_reset();
        bit to;
        int lo, per;
        lo = $urandom_range(0, 15);
        per = $urandom_range(5, 12);
        run_sweep(lo, (lo + 2) % 16, 2, 0, per, 1'b0, 1'b0, to);
        n_checks++;
        if (to || meas_q.size() != 3 || res_q.size() != 3)
            begin n_errors++; $display("FAIL gate0_n: timeout=%b meas=%0d results=%0d, want 0 3 3", to, meas_q.size(), res_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (meas_q[i] != 1 || !cnt_ok(int'(res_q[i].cnt), 1, per))
                begin n_errors++; $display("FAIL gate0_win%0d: window=%0d count=%0d, want 1 and count<=1", i, meas_q[i], res_q[i].cnt); end
        end
        @(posedge clk); #1;
        slot_lo = 4'd9; slot_hi = 4'd12; stage = 5'd31; gate_len = 16'd50; sweep_start = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || ro_start !== 1'b0 || ro_sel !== 4'd9)
            begin n_errors++; $display("FAIL rst_pre: busy=%b start=%b sel=%0d, want 1 0 9", busy, ro_start, ro_sel); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ro_sel !== 4'd0 || ro_stage !== 5'd0 || ro_start !== 1'b0 || res_valid !== 1'b0 || res_slot !== 4'd0 ||
            res_count !== 16'd0 || res_ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid: sel=%0d stage=%0d start=%b valid=%b slot=%0d count=%0d ovf=%b busy=%b done=%b, want all 0",
                     ro_sel, ro_stage, ro_start, res_valid, res_slot, res_count, res_ovf, busy, done);
        end
        rst_n = 1'b1;
        clear_mon();
        repeat (200) @(posedge clk);
        #1;
        n_checks++;
        if (res_q.size() != 0 || done_cnt != 0 || busy !== 1'b0)
            begin n_errors++; $display("FAIL rst_after: results=%0d done=%0d busy=%b, want 0 0 0", res_q.size(), done_cnt, busy); end
    endtask

    task automatic test_back_to_back();
        bit to;
        int lo, len, g, per, stg;
        for (int it = 0; it < 4; it++) begin
            lo = $urandom_range(0, 15);
            len = $urandom_range(1, 16);
            g = $urandom_range(1, 40);
            per = $urandom_range(5, 12);
            stg = $urandom_range(0, 31);
            run_sweep(lo, (lo + len - 1) % 16, stg, g, per, 1'b1, 1'b1, to);
            n_checks++;
            if (to || res_q.size() != n_slots(lo, (lo + len - 1) % 16) || done_cnt != 1) begin
                n_errors++;
                $display("FAIL b2b%0d_n: timeout=%b results=%0d done=%0d, want 0 %0d 1", it, to, res_q.size(), done_cnt, len);
            end else begin
                for (int i = 0; i < len; i++) begin
                    n_checks++;
                    if (res_q[i].slot !== 4'(exp_slot(lo, i)) || !cnt_ok(int'(res_q[i].cnt), g, per) || res_q[i].ovf !== 1'b0) begin
                        n_errors++;
                        $display("FAIL b2b%0d_res%0d: slot=%0d count=%0d ovf=%b, want %0d ~%0d/%0d 0",
                                 it, i, res_q[i].slot, res_q[i].cnt, res_q[i].ovf, exp_slot(lo, i), g, per);
                    end
                end
                n_checks++;
                if (settle_q.size() != len || meas_q.size() != len) begin
                    n_errors++;
                    $display("FAIL b2b%0d_phases: settle=%0d meas=%0d runs, want %0d", it, settle_q.size(), meas_q.size(), len);
                end else begin
                    for (int i = 0; i < len; i++) begin
                        n_checks++;
                        if (settle_q[i] != SETTLE || meas_q[i] != g || sel_q[i] !== 4'(exp_slot(lo, i)) || stg_q[i] !== 5'(stg)) begin
                            n_errors++;
                            $display("FAIL b2b%0d_phase%0d: settle=%0d meas=%0d sel=%0d stage=%0d, want %0d %0d %0d %0d",
                                     it, i, settle_q[i], meas_q[i], sel_q[i], stg_q[i], SETTLE, g, exp_slot(lo, i), stg);
                        end
                    end
                end
            end
            n_checks++;
            if (glitch_cnt != 0 || overlap_cnt != 0)
                begin n_errors++; $display("FAIL b2b%0d_stable: glitches=%0d overlaps=%0d, want 0 0", it, glitch_cnt, overlap_cnt); end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sweep_start = 1'b0; abort = 1'b0; ready = 1'b0;
        slot_lo = '0; slot_hi = '0; stage = '0; gate_len = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_overflow();
        test_abort();
        test_gate0_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ro_sweep_ctrl.md
RO_SWEEP_CTRL -- requirements
Module: ro_sweep_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the edge counter and result.
REQ-002 SHALL have parameter GATE_W, default 16, width of the gate-length input.
REQ-003 SHALL have parameter SETTLE_CYC, default 8, number of stopped-ring cycles before each measurement.
REQ-004 SHALL have port wb_clk_i, input, 1, the single clock. All logic is synchronous to it.
REQ-005 SHALL have port wb_rst_n_i, input, 1, synchronous active-low reset.
REQ-006 SHALL have port sweep_start_i, input, 1, one-cycle request to start a sweep.
REQ-007 SHALL have port abort_i, input, 1, aborts a sweep in progress.
REQ-008 SHALL have ports slot_lo_i and slot_hi_i, input, 4 each, first and last oscillator slot.
REQ-009 SHALL have port stage_sel_i, input, 5, stage-select pattern applied to s1..s5.
REQ-010 SHALL have port gate_len_i, input, GATE_W, measurement window in wb_clk_i cycles.
REQ-011 SHALL have port ro_sig_i, input, 1, asynchronous muxed oscillator output.
REQ-012 SHALL have ports ro_sel_o, output, 4, the oscillator mux select; and ro_stage_o, output, 5, the oscillator stage select.
REQ-013 SHALL have port ro_start_o, output, 1, oscillator enable.
REQ-014 SHALL have result ports, all outputs: res_valid_o (1), res_slot_o (4), res_count_o (CNT_W) and res_ovf_o (1). res_ready_i is the matching input (1).
REQ-015 SHALL have status ports, both outputs: busy_o (1) and done_o (1, single-cycle pulse).

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, MEASURE, REPORT and DONE.
REQ-017 In IDLE, sweep_start_i=1 SHALL latch the configuration inputs and enter SETTLE with ro_sel_o=slot_lo. While busy_o=1, sweep_start_i SHALL be ignored.
REQ-018 gate_len_i=0 SHALL be treated as 1.
REQ-019 The slot sequence SHALL advance lo, lo+1, ..., hi modulo 16. When lo>hi, it wraps through 15 to 0. When lo=hi, one slot is measured.
REQ-020 In SETTLE, ro_start_o=0 and ro_sel_o/ro_stage_o SHALL be stable for exactly SETTLE_CYC cycles, then the FSM enters MEASURE.
REQ-021 In MEASURE, ro_start_o SHALL be 1.
REQ-022 ro_sig_i SHALL pass through a 2-flop synchronizer plus a rising-edge detector. The counter SHALL clear on MEASURE entry and increment once per detected edge for exactly gate_len cycles. The FSM then enters REPORT.
REQ-023 The counter SHALL saturate at 2^CNT_W-1 and set the overflow flag. That flag appears as res_ovf_o.
REQ-024 Counts are valid only for ro_sig_i frequencies below wb_clk_i/4. The block SHALL NOT detect aliasing.
REQ-025 In REPORT, res_valid_o SHALL be 1 and ro_start_o SHALL be 0. res_slot_o, res_count_o and res_ovf_o SHALL be held stable until res_valid_o and res_ready_i are both 1.
REQ-026 On the REPORT handshake, the FSM SHALL go to SETTLE for the next slot, or to DONE after slot hi. res_valid_o SHALL deassert in the following cycle.
REQ-027 DONE SHALL assert done_o for one cycle and then return to IDLE.
REQ-028 busy_o SHALL be 1 in every state except IDLE.
REQ-029 abort_i=1 in any non-IDLE state SHALL return the FSM to IDLE next cycle: ro_start_o=0, res_valid_o=0, and no done_o pulse. abort_i SHALL take priority over a simultaneous handshake or state transition.
REQ-030 If sweep_start_i and abort_i are both 1 in IDLE, the FSM SHALL stay in IDLE.

Reset
REQ-031 With wb_rst_n_i=0 at a clock edge, the FSM SHALL go to IDLE and outputs SHALL take these values:
- ro_sel_o=0, ro_stage_o=0, ro_start_o=0
- res_valid_o=0, res_slot_o=0, res_count_o=0, res_ovf_o=0
- busy_o=0, done_o=0
- synchronizer flops cleared
REQ-032 Reset SHALL take effect mid-sweep without producing a result or done_o.

Structure
REQ-033 The FSM state enum and the SETTLE_CYC, CNT_W and GATE_W defaults SHALL live in a shared package, ro_pkg.
REQ-034 The synchronizer and edge detector SHALL be a sub-module, ro_edge_sync.

Verification
REQ-035 Slots 3..5, gate_len=100, ro_sig_i = wb_clk_i/10 -> three results with slots 3, 4, 5. Each count is 10±1 with ovf=0, followed by one done_o pulse.
REQ-036 slot_lo=14, slot_hi=1 -> result slots 14, 15, 0, 1 in order.
REQ-037 res_ready_i=0 for 20 cycles in REPORT -> result fields stable and ro_start_o=0 throughout. The result is accepted on the first cycle res_ready_i=1.
REQ-038 CNT_W=4, gate_len=200, ro_sig_i = wb_clk_i/5 -> count 15 with ovf=1.
REQ-039 abort_i in MEASURE of the second slot -> IDLE next cycle, busy_o=0, no done_o. A new sweep_start_i then behaves normally.
REQ-040 gate_len=0 -> 1-cycle window. wb_rst_n_i=0 during SETTLE -> all outputs at their REQ-031 reset values on the next cycle.
